// File: rtl/ipv4_ttl_dec.sv
// IPv4 TTL decrement stage: a single registered AXI4-Stream slice that decrements the TTL and patches the header checksum on first beats.
// Optional build macro IPV4_TTL_DEC_STATS_EN adds packet/rewrite/expired counters.
module ipv4_ttl_dec #(
    parameter int C_S_AXIS_TDATA_WIDTH = 256,
    parameter int C_S_AXIS_TUSER_WIDTH = 128
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [C_S_AXIS_TDATA_WIDTH-1:0]   s_axis_tdata,
    input  logic [C_S_AXIS_TDATA_WIDTH/8-1:0] s_axis_tkeep,
    input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
    input  logic                              s_axis_tvalid,
    output logic                              s_axis_tready,
    input  logic                              s_axis_tlast,
    input  logic                              i_dec_ttl,
    output logic [C_S_AXIS_TDATA_WIDTH-1:0]   m_axis_tdata,
    output logic [C_S_AXIS_TDATA_WIDTH/8-1:0] m_axis_tkeep,
    output logic [C_S_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
    output logic                              m_axis_tvalid,
    input  logic                              m_axis_tready,
    output logic                              m_axis_tlast,
`ifdef IPV4_TTL_DEC_STATS_EN
    output logic [31:0]                       o_stat_pkts,
    output logic [31:0]                       o_stat_dec,
    output logic [31:0]                       o_stat_expired,
`endif
    output logic                              o_ttl_expired
);

    // Handshake: a beat moves on a port at a rising edge where valid && ready;
    // valid never depends on ready, and an offered output beat is held until taken.
    typedef enum logic [0:0] {WORD1 = 1'b0, PAYLOAD = 1'b1} state_t;

    state_t state;
    state_t state_next;

    logic                            accept;
    logic                            first_beat;
    logic                            is_ipv4;
    logic [7:0]                      ttl;
    logic [15:0]                     csum;
    logic [16:0]                     s17;
    logic [15:0]                     csum_new;
    logic                            do_dec;
    logic                            expired;
    logic [C_S_AXIS_TDATA_WIDTH-1:0] data_next;

    assign s_axis_tready = !m_axis_tvalid || m_axis_tready;
    assign accept        = s_axis_tvalid && s_axis_tready;
    assign first_beat    = (state == WORD1);

    assign is_ipv4  = (s_axis_tdata[159:144] == 16'h0800) && (s_axis_tdata[143:136] == 8'h45);
    assign ttl      = s_axis_tdata[79:72];
    assign csum     = s_axis_tdata[63:48];

    // TTL sits in the high byte of its header word, so TTL-1 raises the checksum by 0x0100.
    assign s17      = {1'b0, csum} + 17'h00100;
    assign csum_new = s17[15:0] + {15'd0, s17[16]};

    assign do_dec   = first_beat && i_dec_ttl && is_ipv4 && (ttl >= 8'd2);
    assign expired  = first_beat && i_dec_ttl && is_ipv4 && (ttl <= 8'd1);

    always_comb begin
        state_next = state;
        data_next  = s_axis_tdata;
        if (accept) begin
            case (state)
                WORD1:   if (!s_axis_tlast) state_next = PAYLOAD;
                PAYLOAD: if (s_axis_tlast)  state_next = WORD1;
                default: state_next = WORD1;
            endcase
        end
        if (do_dec) begin
            data_next[79:72] = ttl - 8'd1;
            data_next[63:48] = csum_new;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= WORD1;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            m_axis_tvalid <= 1'b0;
            m_axis_tlast  <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tkeep  <= '0;
            m_axis_tuser  <= '0;
            o_ttl_expired <= 1'b0;
        end else if (accept) begin
            m_axis_tvalid <= 1'b1;
            m_axis_tlast  <= s_axis_tlast;
            m_axis_tdata  <= data_next;
            m_axis_tkeep  <= s_axis_tkeep;
            m_axis_tuser  <= s_axis_tuser;
            o_ttl_expired <= expired;
        end else if (m_axis_tready) begin
            m_axis_tvalid <= 1'b0;
        end
    end

`ifdef IPV4_TTL_DEC_STATS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            o_stat_pkts    <= '0;
            o_stat_dec     <= '0;
            o_stat_expired <= '0;
        end else if (accept && first_beat) begin
            o_stat_pkts    <= o_stat_pkts + 32'd1;
            if (do_dec)  o_stat_dec     <= o_stat_dec + 32'd1;
            if (expired) o_stat_expired <= o_stat_expired + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_ipv4_ttl_dec.sv
// Self-checking bench for ipv4_ttl_dec: directed packets, back-pressure, mid-packet reset and a small random set.
module tb_ipv4_ttl_dec;

    localparam int W = 256 + 32 + 128 + 1 + 1;

    logic         clk;
    logic         reset;
    logic [255:0] s_axis_tdata;
    logic [31:0]  s_axis_tkeep;
    logic [127:0] s_axis_tuser;
    logic         s_axis_tvalid;
    logic         s_axis_tready;
    logic         s_axis_tlast;
    logic         i_dec_ttl;
    logic [255:0] m_axis_tdata;
    logic [31:0]  m_axis_tkeep;
    logic [127:0] m_axis_tuser;
    logic         m_axis_tvalid;
    logic         m_axis_tready;
    logic         m_axis_tlast;
    logic         o_ttl_expired;
`ifdef IPV4_TTL_DEC_STATS_EN
    logic [31:0]  o_stat_pkts;
    logic [31:0]  o_stat_dec;
    logic [31:0]  o_stat_expired;
`endif

    int n_checks = 0;
    int n_err    = 0;
    logic mon_en = 1'b0;
    logic [W-1:0] exp_q[$];

    ipv4_ttl_dec dut (
        .clk           (clk),
        .reset         (reset),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tkeep  (s_axis_tkeep),
        .s_axis_tuser  (s_axis_tuser),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .s_axis_tlast  (s_axis_tlast),
        .i_dec_ttl     (i_dec_ttl),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tkeep  (m_axis_tkeep),
        .m_axis_tuser  (m_axis_tuser),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tlast  (m_axis_tlast),
`ifdef IPV4_TTL_DEC_STATS_EN
        .o_stat_pkts   (o_stat_pkts),
        .o_stat_dec    (o_stat_dec),
        .o_stat_expired(o_stat_expired),
`endif
        .o_ttl_expired (o_ttl_expired)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [255:0] rnd256();
        return {$urandom(), $urandom(), $urandom(), $urandom(),
                $urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    function automatic logic [255:0] mk_hdr(input logic [15:0] et, input logic [7:0] vi,
                                            input logic [7:0] t, input logic [15:0] cs,
                                            input logic [255:0] fill);
        logic [255:0] d;
        d = fill;
        d[159:144] = et;
        d[143:136] = vi;
        d[79:72]   = t;
        d[63:48]   = cs;
        return d;
    endfunction

    // Reference for first beats: ones'-complement add of 0x0100 done in integer arithmetic.
    task automatic model(input logic [255:0] d, input logic dec,
                         output logic [255:0] ed, output logic ee);
        int t;
        ed = d;
        ee = 1'b0;
        if (dec && d[159:144] == 16'h0800 && d[143:136] == 8'h45) begin
            if (d[79:72] < 8'd2) begin
                ee = 1'b1;
            end else begin
                ed[79:72] = d[79:72] - 8'd1;
                t = int'(d[63:48]) + 256;
                if (t > 65535) t = t - 65535;
                ed[63:48] = t[15:0];
            end
        end
    endtask

    // driver: offer one beat, queue its expected output, wait until accepted
    task automatic send(input logic [255:0] d, input logic last, input logic dec,
                        input logic [255:0] ed, input logic ee);
        logic [31:0]  k;
        logic [127:0] u;
        logic         ok;
        int           n;
        k = $urandom();
        u = {$urandom(), $urandom(), $urandom(), $urandom()};
        s_axis_tdata  = d;
        s_axis_tkeep  = k;
        s_axis_tuser  = u;
        s_axis_tlast  = last;
        i_dec_ttl     = dec;
        s_axis_tvalid = 1'b1;
        exp_q.push_back({ed, k, u, last, ee});
        ok = 1'b0;
        n  = 0;
        while (!ok && n < 100) begin
            @(negedge clk);
            ok = s_axis_tready;
            @(posedge clk);
            #1;
            n++;
        end
        if (!ok) begin
            n_checks++;
            n_err++;
            $error("FAIL accept_timeout observed=%0d expected=accepted", n);
        end
        s_axis_tvalid = 1'b0;
        i_dec_ttl     = $urandom_range(0, 1);
    endtask

    // scoreboard monitor
    always @(negedge clk) begin
        logic [W-1:0] e;
        if (mon_en) begin
            check("s_ready", {255'd0, s_axis_tready}, {255'd0, !(m_axis_tvalid && !m_axis_tready)});
            if (m_axis_tvalid) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_err++;
                    $error("FAIL unexpected_beat observed=%h expected=none", m_axis_tdata);
                end else begin
                    e = m_axis_tready ? exp_q.pop_front() : exp_q[0];
                    check("tdata",   m_axis_tdata, e[W-1 -: 256]);
                    check("tkeep",   {224'd0, m_axis_tkeep}, {224'd0, e[161:130]});
                    check("tuser",   {128'd0, m_axis_tuser}, {128'd0, e[129:2]});
                    check("tlast",   {255'd0, m_axis_tlast}, {255'd0, e[1]});
                    check("expired", {255'd0, o_ttl_expired}, {255'd0, e[0]});
                end
            end
        end
    end

    initial begin
        logic [255:0] f;
        logic [255:0] d;
        logic [255:0] ed;
        logic         ee;
        logic         dec;
        reset         = 1'b1;
        s_axis_tdata  = '0;
        s_axis_tkeep  = '0;
        s_axis_tuser  = '0;
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        i_dec_ttl     = 1'b0;
        m_axis_tready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_tvalid",  {255'd0, m_axis_tvalid}, 256'd0);
        check("rst_tlast",   {255'd0, m_axis_tlast}, 256'd0);
        check("rst_expired", {255'd0, o_ttl_expired}, 256'd0);
        check("rst_tdata",   m_axis_tdata, 256'd0);
        check("rst_tkeep",   {224'd0, m_axis_tkeep}, 256'd0);
        check("rst_tuser",   {128'd0, m_axis_tuser}, 256'd0);
`ifdef IPV4_TTL_DEC_STATS_EN
        check("rst_pkts", {224'd0, o_stat_pkts}, 256'd0);
`endif
        reset  = 1'b0;
        mon_en = 1'b1;

        // 2-beat IPv4, TTL 64, csum B1E6
        f = rnd256();
        send(mk_hdr(16'h0800, 8'h45, 8'd64, 16'hB1E6, f), 1'b0, 1'b1,
             mk_hdr(16'h0800, 8'h45, 8'd63, 16'hB2E6, f), 1'b0);
        d = mk_hdr(16'h0800, 8'h45, 8'd40, 16'h1234, rnd256());
        send(d, 1'b1, 1'b1, d, 1'b0);

        // checksum end-around carry cases
        f = rnd256();
        send(mk_hdr(16'h0800, 8'h45, 8'd10, 16'hFF00, f), 1'b1, 1'b1,
             mk_hdr(16'h0800, 8'h45, 8'd9, 16'h0001, f), 1'b0);
        f = rnd256();
        send(mk_hdr(16'h0800, 8'h45, 8'd10, 16'hFEFF, f), 1'b1, 1'b1,
             mk_hdr(16'h0800, 8'h45, 8'd9, 16'hFFFF, f), 1'b0);

        // expired: TTL 1 (2 beats, non-first beat looks like IPv4 TTL 0), then TTL 0
        d = mk_hdr(16'h0800, 8'h45, 8'd1, 16'hABCD, rnd256());
        send(d, 1'b0, 1'b1, d, 1'b1);
        d = mk_hdr(16'h0800, 8'h45, 8'd0, 16'h0000, rnd256());
        send(d, 1'b1, 1'b1, d, 1'b0);
        d = mk_hdr(16'h0800, 8'h45, 8'd0, 16'h5555, rnd256());
        send(d, 1'b1, 1'b1, d, 1'b1);

        // pass-through: ARP, IP options, no decrement request
        d = mk_hdr(16'h0806, 8'h45, 8'd64, 16'h1111, rnd256());
        send(d, 1'b1, 1'b1, d, 1'b0);
        d = mk_hdr(16'h0800, 8'h46, 8'd64, 16'h2222, rnd256());
        send(d, 1'b1, 1'b1, d, 1'b0);
        d = mk_hdr(16'h0800, 8'h45, 8'd64, 16'h3333, rnd256());
        send(d, 1'b1, 1'b0, d, 1'b0);

        // back-pressure: 3 back-to-back single-beat packets, tready 1,0,0,1,1
        fork
            begin
                for (int i = 0; i < 3; i++) begin
                    f = rnd256();
                    send(mk_hdr(16'h0800, 8'h45, 8'd20 + 8'(i), 16'h4000 + 16'(i), f), 1'b1, 1'b1,
                         mk_hdr(16'h0800, 8'h45, 8'd19 + 8'(i), 16'h4100 + 16'(i), f), 1'b0);
                end
            end
            begin
                logic [4:0] pat;
                pat = 5'b11001;
                for (int i = 0; i < 5; i++) begin
                    m_axis_tready = pat[i];
                    @(posedge clk);
                    #1;
                end
                m_axis_tready = 1'b1;
            end
        join

        // reset on beat 2 of a 4-beat packet
        repeat (2) @(posedge clk);
        #1;
        f = rnd256();
        send(mk_hdr(16'h0800, 8'h45, 8'd30, 16'h0F00, f), 1'b0, 1'b1,
             mk_hdr(16'h0800, 8'h45, 8'd29, 16'h1000, f), 1'b0);
        reset         = 1'b1;
        s_axis_tdata  = rnd256();
        s_axis_tlast  = 1'b0;
        s_axis_tvalid = 1'b1;
        @(posedge clk);
        #1;
        reset         = 1'b0;
        s_axis_tvalid = 1'b0;
        check("mid_rst_tvalid", {255'd0, m_axis_tvalid}, 256'd0);
        f = rnd256();
        send(mk_hdr(16'h0800, 8'h45, 8'd5, 16'h0A0A, f), 1'b1, 1'b1,
             mk_hdr(16'h0800, 8'h45, 8'd4, 16'h0B0A, f), 1'b0);
`ifdef IPV4_TTL_DEC_STATS_EN
        check("stat_pkts",    {224'd0, o_stat_pkts}, 256'd1);
        check("stat_dec",     {224'd0, o_stat_dec}, 256'd1);
        check("stat_expired", {224'd0, o_stat_expired}, 256'd0);
`endif

        // random single-beat packets against the reference
        for (int i = 0; i < 8; i++) begin
            d = mk_hdr(($urandom_range(0, 3) != 0) ? 16'h0800 : 16'h0806,
                       ($urandom_range(0, 3) != 0) ? 8'h45 : 8'h46,
                       ($urandom_range(0, 2) == 0) ? 8'($urandom_range(0, 2)) : 8'($urandom_range(0, 255)),
                       16'($urandom_range(0, 65535)), rnd256());
            dec = ($urandom_range(0, 3) != 0);
            model(d, dec, ed, ee);
            send(d, 1'b1, dec, ed, ee);
        end

        m_axis_tready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("queue_drained", 256'(exp_q.size()), 256'd0);
        mon_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
